// File: rtl/pop_count_seq.sv
// pop_count_seq: sequential 128-bit population count.
// A word is reduced in seven SWAR steps. Each step adds the working register
// to a copy of itself shifted right by 2^k, under mask M_k. An external
// combinational shift stage does the shifting, requested through a one-hot command.
// Optional feature macro: POP_COUNT_ACCUM_EN adds a saturating 16-bit running
// sum of delivered counts. Without it, o_accum reads zero.
module pop_count_seq (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_valid,
  input  logic [127:0] i_data,
  output logic         o_ready,
  output logic [6:0]   o_shift_command,
  input  logic [127:0] i_shifted_data,
  output logic [127:0] o_work,
  output logic         o_valid,
  output logic [7:0]   o_count,
  input  logic         i_ready,
  input  logic         i_accum_clr,
  output logic [15:0]  o_accum
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [2:0]     k_q, k_d;
  logic [127:0]   work_q, work_d;
  logic [127:0]   mask;

  // Field mask for reduction step k; fields double in width each step.
  function automatic logic [127:0] step_mask(input logic [2:0] k);
    logic [127:0] m;
    case (k)
      3'd0:    m = {64{2'b01}};
      3'd1:    m = {32{4'b0011}};
      3'd2:    m = {16{8'h0F}};
      3'd3:    m = {8{16'h00FF}};
      3'd4:    m = {4{32'h0000_FFFF}};
      3'd5:    m = {2{64'h0000_0000_FFFF_FFFF}};
      3'd6:    m = {64'h0, {64{1'b1}}};
      default: m = '0;
    endcase
    return m;
  endfunction

  assign mask = step_mask(k_q);

  // State, step counter and working register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      k_q     <= 3'd0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      work_q  <= work_d;
    end
  end

  // Next-state, reduction datapath and handshake outputs.
  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    work_d          = work_q;
    o_ready         = 1'b0;
    o_valid         = 1'b0;
    o_shift_command = 7'd0;
    case (state_q)
      StIdle: begin
        o_ready = 1'b1;
        if (i_valid) begin
          work_d  = i_data;
          k_d     = 3'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        o_shift_command = 7'd1 << k_q;
        // Field sums never overflow their field, so a full-width add is exact.
        work_d = (work_q & mask) + (i_shifted_data & mask);
        if (k_q == 3'd6) begin
          state_d = StDone;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      StDone: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_work  = work_q;
  assign o_count = work_q[7:0];

`ifdef POP_COUNT_ACCUM_EN
  logic [15:0] accum_q, accum_d;
  logic [16:0] accum_sum;
  logic        handshake;

  assign handshake = o_valid & i_ready;
  assign accum_sum = {1'b0, accum_q} + {9'd0, o_count};

  // Running sum: clear takes effect before a coincident add.
  always_comb begin
    accum_d = accum_q;
    if (handshake) begin
      if (i_accum_clr) begin
        accum_d = {8'd0, o_count};
      end else begin
        accum_d = accum_sum[16] ? 16'hFFFF : accum_sum[15:0];
      end
    end else if (i_accum_clr) begin
      accum_d = 16'd0;
    end
  end

  // Accumulator register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      accum_q <= 16'd0;
    end else begin
      accum_q <= accum_d;
    end
  end

  assign o_accum = accum_q;
`else
  logic unused_accum_clr;
  assign unused_accum_clr = i_accum_clr;
  assign o_accum          = 16'h0000;
`endif

endmodule

// File: tb/tb_pop_count_seq.sv
// Self-checking bench for pop_count_seq. The shift stage is modelled here. A
// cycle-age model predicts the handshake outputs, and the expected count comes
// from $countones of the accepted word. Honours POP_COUNT_ACCUM_EN when defined.
module tb_pop_count_seq;

  logic         i_clk;
  logic         i_reset_n;
  logic         i_valid;
  logic [127:0] i_data;
  logic         o_ready;
  logic [6:0]   o_shift_command;
  logic [127:0] i_shifted_data;
  logic [127:0] o_work;
  logic         o_valid;
  logic [7:0]   o_count;
  logic         i_ready;
  logic         i_accum_clr;
  logic [15:0]  o_accum;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Model state: cycles since accept (0 = idle, 8 = count on offer).
  int m_age = 0;
  int m_cnt = 0;
  int m_acc = 0;

  pop_count_seq dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_valid         (i_valid),
    .i_data          (i_data),
    .o_ready         (o_ready),
    .o_shift_command (o_shift_command),
    .i_shifted_data  (i_shifted_data),
    .o_work          (o_work),
    .o_valid         (o_valid),
    .o_count         (o_count),
    .i_ready         (i_ready),
    .i_accum_clr     (i_accum_clr),
    .o_accum         (o_accum)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Shift stage: right shift by 2^i for command bit i.
  always_comb begin
    i_shifted_data = o_work;
    for (int i = 0; i < 7; i++) begin
      if (o_shift_command[i]) i_shifted_data = o_work >> (1 << i);
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model, advanced on the same edges as the DUT.
  always @(posedge i_clk) begin
    if (!i_reset_n) begin
      m_age = 0;
      m_cnt = 0;
      m_acc = 0;
    end else begin
`ifdef POP_COUNT_ACCUM_EN
      if (m_age == 8 && i_ready) begin
        if (i_accum_clr) m_acc = m_cnt;
        else m_acc = (m_acc + m_cnt > 65535) ? 65535 : m_acc + m_cnt;
      end else if (i_accum_clr) begin
        m_acc = 0;
      end
`endif
      if (m_age == 0) begin
        if (i_valid) begin
          m_age = 1;
          m_cnt = $countones(i_data);
        end
      end else if (m_age < 8) begin
        m_age++;
      end else if (i_ready) begin
        m_age = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("cyc_ready", o_ready, m_age == 0);
      check("cyc_valid", o_valid, m_age == 8);
      check("cyc_cmd", o_shift_command,
            (m_age >= 1 && m_age <= 7) ? (7'd1 << (m_age - 1)) : 7'd0);
      if (m_age == 8) begin
        check("cyc_count", o_count, m_cnt);
        check("cyc_work", o_work, m_cnt);
      end
      check("cyc_accum", o_accum, m_acc);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Accept one word from IDLE, check the command sequence, the literal count and the handshake.
  task automatic run_word(input logic [127:0] data, input logic [7:0] exp);
    i_valid = 1'b1;
    i_data  = data;
    tick();
    i_valid = 1'b0;
    i_data  = {4{$urandom()}};
    for (int j = 0; j < 7; j++) begin
      check("run_cmd", o_shift_command, 7'd1 << j);
      tick();
    end
    check("done_valid", o_valid, 1'b1);
    check("done_count", o_count, exp);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    i_reset_n   = 1'b0;
    i_valid     = 1'b0;
    i_data      = '0;
    i_ready     = 1'b1;
    i_accum_clr = 1'b0;
    repeat (3) tick();
    check("rst_ready", o_ready, 1'b1);
    check("rst_valid", o_valid, 1'b0);
    check("rst_cmd", o_shift_command, 7'd0);
    check("rst_count", o_count, 8'd0);
    check("rst_work", o_work, 128'd0);
    check("rst_accum", o_accum, 16'd0);
    i_reset_n = 1'b1;
    chk_en    = 1'b1;
    tick();

    // Directed words.
    run_word(128'd0, 8'h00);
    run_word({128{1'b1}}, 8'h80);
    run_word({32{4'hA}}, 8'h40);
    run_word(128'h1, 8'h01);
    run_word({1'b1, 126'd0, 1'b1}, 8'h02);
    run_word(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 8'h40);

    // Backpressure: count held, new words ignored.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 128'hF0;
    tick();
    i_valid = 1'b0;
    repeat (7) tick();
    for (int j = 0; j < 5; j++) begin
      i_valid = 1'b1;
      i_data  = {128{1'b1}};
      check("bp_valid", o_valid, 1'b1);
      check("bp_count", o_count, 8'h04);
      check("bp_ready", o_ready, 1'b0);
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    check("bp_release", o_count, 8'h04);
    tick();
    check("bp_idle_ready", o_ready, 1'b1);
    check("bp_idle_valid", o_valid, 1'b0);

    // Reset at RUN step 3.
    i_valid = 1'b1;
    i_data  = {128{1'b1}};
    tick();
    i_valid = 1'b0;
    repeat (3) tick();
    check("mid_cmd_k3", o_shift_command, 7'h08);
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    check("mrst_ready", o_ready, 1'b1);
    check("mrst_valid", o_valid, 1'b0);
    check("mrst_cmd", o_shift_command, 7'd0);
    check("mrst_work", o_work, 128'd0);
    run_word(128'hFF00, 8'h08);

    // Back-to-back: accepts must be exactly 9 cycles apart.
    i_valid = 1'b1;
    i_data  = {128{1'b1}};
    for (int c = 0; c < 30; c++) begin
      if (o_ready) q.push_back(c);
      tick();
    end
    i_valid = 1'b0;
    check("b2b_accepts", q.size() >= 3, 1'b1);
    for (int i = 1; i < q.size(); i++) check("b2b_spacing", q[i] - q[i-1], 9);
    repeat (10) tick();

    // Lone clear pulse (ignored without the accumulator).
    i_accum_clr = 1'b1;
    tick();
    i_accum_clr = 1'b0;
    check("clr_alone", o_accum, 16'd0);

`ifdef POP_COUNT_ACCUM_EN
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    run_word({128{1'b1}}, 8'h80);
    run_word({32{4'hA}}, 8'h40);
    run_word(128'h1, 8'h01);
    check("acc_c1", o_accum, 16'h00C1);
    for (int i = 0; i < 513; i++) run_word({128{1'b1}}, 8'h80);
    check("acc_sat", o_accum, 16'hFFFF);
    i_valid = 1'b1;
    i_data  = 128'h1F;
    tick();
    i_valid = 1'b0;
    repeat (7) tick();
    i_accum_clr = 1'b1;
    tick();
    i_accum_clr = 1'b0;
    check("acc_clr_hs", o_accum, 16'h0005);
`endif

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pop_count_seq.md
# pop_count_seq

Sequential population-count engine for the correlator XOR datapath. It accepts one 128-bit XOR result word and produces the word's bit count (0–128) over seven SWAR reduction steps. It drives the one-hot shift stage through `o_shift_command` and consumes that stage's combinational result on `i_shifted_data`. It hands the count downstream to the correlation accumulator over a valid/ready handshake.

## Interface

- No parameters; widths fixed (128-bit word, 8-bit count, 16-bit accumulator).

Ports:
- `i_clk`  in  1  sole clock, all state on rising edge
- `i_reset_n`  in  1  reset, synchronous, active-low
- `i_valid`  in  1  upstream word valid
- `i_data`  in  128  XOR result word
- `o_ready`  out  1  block can accept a word (IDLE only)
- `o_shift_command`  out  7  one-hot shift request to the shift stage; 0 = no shift
- `i_shifted_data`  in  128  shift stage output, combinational function of `o_work` and `o_shift_command`
- `o_work`  out  128  working register, fed to the shift stage's data input
- `o_valid`  out  1  count valid
- `o_count`  out  8  population count of the accepted word
- `i_ready`  in  1  downstream accepts count
- `i_accum_clr`  in  1  clear running sum (only with `POP_COUNT_ACCUM_EN`)
- `o_accum`  out  16  running sum of delivered counts (only with `POP_COUNT_ACCUM_EN`)

## Operation

- FSM states: IDLE, RUN, DONE; 3-bit step counter `k` (0..6).
- IDLE:
  - `o_ready`=1, `o_shift_command`=0.
  - On `i_valid & o_ready`: `o_work` <= `i_data`, `k` <= 0, go to RUN.
- RUN:
  - `o_shift_command` = 1<<k.
  - Each cycle: `o_work` <= (`o_work` & M_k) + (`i_shifted_data` & M_k).
  - Masks M_k: k=0 0x5555…; k=1 0x3333…; k=2 0x0F0F…; k=3 0x00FF…; k=4 0x0000FFFF repeated; k=5 0x00000000FFFFFFFF repeated; k=6 low 64 bits set.
  - Each add is field-wise and never carries across fields, so a plain 128-bit add is correct.
  - At k=6: go to DONE. Otherwise `k` <= k+1.
- DONE:
  - `o_valid`=1, `o_count` = `o_work[7:0]`, `o_shift_command`=0.
  - On `i_ready`: go to IDLE.
  - `o_count` and `o_work` hold stable while waiting.
- `o_count` is meaningful only while `o_valid`=1. It reads `o_work[7:0]` in all states.

## Timing

- Reset (`i_reset_n`=0 at an edge) forces:
  - state=IDLE, `k`=0, `o_work`=0, `o_shift_command`=0
  - `o_valid`=0, `o_count`=0, `o_ready`=1, `o_accum`=0
- Reset mid-RUN or mid-DONE discards the word; no count is emitted.
- Latency: accept edge at cycle A; RUN occupies A+1..A+7; `o_valid` rises in cycle A+8.
- Throughput: with `i_ready` held high, one word per 9 cycles. `o_ready` is low in RUN and DONE; there is no accept in DONE.
- `i_valid` outside IDLE is ignored, and `i_data` is not sampled.
- `o_valid` is held until `i_ready`. `o_valid` never drops without a handshake, except on reset.
- `i_shifted_data` must settle within the same cycle; no registers exist in the shift path.

## Configuration

- `POP_COUNT_ACCUM_EN` defined:
  - 16-bit `o_accum` register. On each output handshake (`o_valid & i_ready`), it adds `o_count`, saturating at 0xFFFF.
  - `i_accum_clr` is synchronous. If asserted in the same cycle as a handshake, `o_accum` <= `o_count` (clear, then add). If asserted alone, `o_accum` <= 0.
- Undefined:
  - `o_accum` tied to 16'h0000.
  - `i_accum_clr` is ignored; no accumulator register is built.

## Test plan

- `i_data`=0 -> `o_valid` in cycle A+8 with `o_count`=0. `o_shift_command` sequence in RUN is 0x01,0x02,0x04,…,0x40.
- `i_data`=all ones -> `o_count`=0x80. `i_data`=0xAAAA…AA -> 0x40. `i_data`=128'h1 -> 0x01. `i_data`=128'h8000…0001 -> 0x02.
- Backpressure: `i_ready`=0 for 5 cycles after `o_valid` -> `o_valid`/`o_count` stable, `o_ready`=0, new `i_valid` ignored. `i_ready`=1 -> IDLE next cycle.
- Reset asserted at RUN step 3 -> next cycle all outputs at reset values; the next word's count is correct.
- Back-to-back words with `i_valid`/`i_ready` always high -> accept edges exactly 9 cycles apart.
- `POP_COUNT_ACCUM_EN`:
  - 3 words (0x80, 0x40, 0x01) -> `o_accum`=0x00C1.
  - 513 all-ones words -> 0xFFFF (saturated).
  - `i_accum_clr` coincident with a handshake of count 0x05 -> 0x0005.
